// File: rtl/ps2_kbd_ctrl_if.sv
// Avalon-MM slave bus bundle for the PS/2 keyboard host controller.
// Signals:
//   avs_s1_address   [1:0]  register select
//   avs_s1_read             read strobe
//   avs_s1_write            write strobe
//   avs_s1_writedata [7:0]  write data
//   avs_s1_readdata  [7:0]  read data, registered in the slave, valid one cycle after read
// Modports: master (bus driver / testbench), slave (controller).
interface ps2_kbd_ctrl_if;
  logic [1:0] avs_s1_address;
  logic       avs_s1_read;
  logic       avs_s1_write;
  logic [7:0] avs_s1_writedata;
  logic [7:0] avs_s1_readdata;

  modport master (
    output avs_s1_address,
    output avs_s1_read,
    output avs_s1_write,
    output avs_s1_writedata,
    input  avs_s1_readdata
  );

  modport slave (
    input  avs_s1_address,
    input  avs_s1_read,
    input  avs_s1_write,
    input  avs_s1_writedata,
    output avs_s1_readdata
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard host controller with an Avalon-MM register interface.
// Receives device-to-host frames into a scancode FIFO (with level interrupt)
// and sequences host-to-device byte transmission on the shared open-drain
// clock/data pair. Transmission owns the lines while active; reception is
// suspended (and any partial frame dropped) until the transmitter is idle.
// Ports:
//   csi_clk       system clock
//   csi_reset_n   asynchronous active-low reset
//   avs           Avalon-MM slave bundle (address/read/write/writedata/readdata)
//   ins_irq0_irq  level interrupt: irq_en & FIFO non-empty, registered
//   coe_kc_i      PS/2 clock pin input
//   coe_kd_i      PS/2 data pin input
//   coe_kc_oe     1 = pull PS/2 clock low
//   coe_kd_oe     1 = pull PS/2 data low
// Registers: 0 R FIFO pop | 1 R status, W control | 2 W transmit byte | 3 unused
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH     = 16,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              csi_clk,
  input  logic              csi_reset_n,
  ps2_kbd_ctrl_if.slave     avs,
  output logic              ins_irq0_irq,
  input  logic              coe_kc_i,
  input  logic              coe_kd_i,
  output logic              coe_kc_oe,
  output logic              coe_kd_oe
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_INHIBIT = 3'd1,
    TX_REQ     = 3'd2,
    TX_DATA    = 3'd3,
    TX_ACK     = 3'd4
  } tx_state_t;

  // Parity bit that makes the 9-bit {parity, data} group contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // ---------------- input synchronizers ----------------
  logic kc_meta_r, kc_sync_r, kc_prev_r;
  logic kd_meta_r, kd_sync_r;
  logic kc_fall_s;

  // Two-flop synchronizers; idle-high reset value avoids a spurious edge after reset.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      kc_meta_r <= 1'b1;
      kc_sync_r <= 1'b1;
      kc_prev_r <= 1'b1;
      kd_meta_r <= 1'b1;
      kd_sync_r <= 1'b1;
    end else begin
      kc_meta_r <= coe_kc_i;
      kc_sync_r <= kc_meta_r;
      kc_prev_r <= kc_sync_r;
      kd_meta_r <= coe_kd_i;
      kd_sync_r <= kd_meta_r;
    end
  end

  assign kc_fall_s = kc_prev_r & ~kc_sync_r;

  // ---------------- bus decode ----------------
  logic [AW:0]   count_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic          nonempty_s, full_s, pop_s, push_s;
  logic          wr_ctrl_s, wr_tx_s;

  assign nonempty_s = (count_r != {(AW+1){1'b0}});
  assign full_s     = (count_r == FULL_CNT);
  assign pop_s      = avs.avs_s1_read  & (avs.avs_s1_address == 2'd0) & nonempty_s;
  assign wr_ctrl_s  = avs.avs_s1_write & (avs.avs_s1_address == 2'd1);
  assign wr_tx_s    = avs.avs_s1_write & (avs.avs_s1_address == 2'd2);

  // ---------------- transmit FSM ----------------
  tx_state_t     tx_state_r, tx_state_n;
  logic [CW-1:0] tx_cnt_r, tx_cnt_n;
  logic [3:0]    tx_idx_r, tx_idx_n;
  logic [8:0]    tx_sr_r, tx_sr_n;
  logic          kc_oe_r, kc_oe_n, kd_oe_r, kd_oe_n;
  logic          tx_err_set_s, tx_busy_s;

  assign tx_busy_s = (tx_state_r != TX_IDLE);

  // Transmit state register and registered line drivers.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= {CW{1'b0}};
      tx_idx_r   <= 4'd0;
      tx_sr_r    <= 9'd0;
      kc_oe_r    <= 1'b0;
      kd_oe_r    <= 1'b0;
    end else begin
      tx_state_r <= tx_state_n;
      tx_cnt_r   <= tx_cnt_n;
      tx_idx_r   <= tx_idx_n;
      tx_sr_r    <= tx_sr_n;
      kc_oe_r    <= kc_oe_n;
      kd_oe_r    <= kd_oe_n;
    end
  end

  // Transmit next-state logic; the counter times the inhibit phase, then the gap between device clocks.
  always_comb begin
    tx_state_n   = tx_state_r;
    tx_cnt_n     = tx_cnt_r;
    tx_idx_n     = tx_idx_r;
    tx_sr_n      = tx_sr_r;
    kc_oe_n      = kc_oe_r;
    kd_oe_n      = kd_oe_r;
    tx_err_set_s = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (wr_tx_s) begin
          tx_state_n = TX_INHIBIT;
          tx_sr_n    = {odd_parity(avs.avs_s1_writedata), avs.avs_s1_writedata};
          tx_cnt_n   = {CW{1'b0}};
          tx_idx_n   = 4'd0;
          kc_oe_n    = 1'b1;
          kd_oe_n    = 1'b0;
        end else begin
          kc_oe_n = 1'b0;
          kd_oe_n = 1'b0;
        end
      end
      TX_INHIBIT: begin
        // Release clock and pull data low together: the request-to-send.
        if (tx_cnt_r == INH_LAST) begin
          tx_state_n = TX_REQ;
          tx_cnt_n   = {CW{1'b0}};
          kc_oe_n    = 1'b0;
          kd_oe_n    = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt_r + CNT_ONE;
        end
      end
      TX_REQ, TX_DATA, TX_ACK: begin
        if (kc_fall_s) begin
          tx_cnt_n = {CW{1'b0}};
          if (tx_state_r == TX_REQ) begin
            kd_oe_n    = ~tx_sr_r[0];
            tx_idx_n   = 4'd1;
            tx_state_n = TX_DATA;
          end else if (tx_state_r == TX_DATA) begin
            // Indices 1..8 cover d1..d7 and parity; index 9 releases data for the stop bit.
            if (tx_idx_r == 4'd9) begin
              kd_oe_n    = 1'b0;
              tx_state_n = TX_ACK;
            end else begin
              kd_oe_n  = ~tx_sr_r[tx_idx_r];
              tx_idx_n = tx_idx_r + 4'd1;
            end
          end else begin
            // Device acknowledges by holding data low on this clock.
            tx_err_set_s = kd_sync_r;
            kc_oe_n      = 1'b0;
            kd_oe_n      = 1'b0;
            tx_state_n   = TX_IDLE;
          end
        end else if (tx_cnt_r == TMO_LAST) begin
          tx_err_set_s = 1'b1;
          kc_oe_n      = 1'b0;
          kd_oe_n      = 1'b0;
          tx_state_n   = TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        kc_oe_n    = 1'b0;
        kd_oe_n    = 1'b0;
      end
    endcase
  end

  // ---------------- receiver ----------------
  logic [3:0]    rx_cnt_r, rx_cnt_n;
  logic [9:0]    rx_sr_r, rx_sr_n;
  logic [CW-1:0] rx_tmr_r, rx_tmr_n;
  logic          rx_done_s, rx_err_set_s, frame_ok_s, ovf_set_s;

  // After ten shifts: [0] start, [8:1] data, [9] parity; stop bit is the current sample.
  assign frame_ok_s = ~rx_sr_r[0] & kd_sync_r & (^rx_sr_r[9:1]);

  // Receiver state registers.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      rx_cnt_r <= 4'd0;
      rx_sr_r  <= 10'd0;
      rx_tmr_r <= {CW{1'b0}};
    end else begin
      rx_cnt_r <= rx_cnt_n;
      rx_sr_r  <= rx_sr_n;
      rx_tmr_r <= rx_tmr_n;
    end
  end

  // Frame assembly, validation and inter-bit timeout; held in reset while transmitting.
  always_comb begin
    rx_cnt_n     = rx_cnt_r;
    rx_sr_n      = rx_sr_r;
    rx_tmr_n     = rx_tmr_r;
    rx_done_s    = 1'b0;
    rx_err_set_s = 1'b0;
    if (tx_busy_s) begin
      rx_cnt_n = 4'd0;
      rx_tmr_n = {CW{1'b0}};
    end else if (kc_fall_s) begin
      rx_tmr_n = {CW{1'b0}};
      if (rx_cnt_r == 4'd10) begin
        rx_cnt_n     = 4'd0;
        rx_done_s    = frame_ok_s;
        rx_err_set_s = ~frame_ok_s;
      end else begin
        rx_sr_n  = {kd_sync_r, rx_sr_r[9:1]};
        rx_cnt_n = rx_cnt_r + 4'd1;
      end
    end else if (rx_cnt_r != 4'd0) begin
      if (rx_tmr_r == TMO_LAST) begin
        rx_cnt_n     = 4'd0;
        rx_tmr_n     = {CW{1'b0}};
        rx_err_set_s = 1'b1;
      end else begin
        rx_tmr_n = rx_tmr_r + CNT_ONE;
      end
    end else begin
      rx_tmr_n = {CW{1'b0}};
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s    = rx_done_s & (~full_s | pop_s);
  assign ovf_set_s = rx_done_s & full_s & ~pop_s;

  // ---------------- FIFO ----------------
  // FIFO pointers and occupancy.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge csi_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rx_sr_r[8:1];
    end
  end

  // ---------------- status flags, readback, irq ----------------
  logic       irq_en_r, tx_err_r, rx_err_r, rx_ovf_r, irq_r;
  logic [7:0] readdata_r, status_s;

  assign status_s = {tx_err_r, rx_err_r, rx_ovf_r, tx_busy_s, irq_en_r, 1'b0, full_s, nonempty_s};

  // Sticky error flags: a new event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      irq_en_r <= 1'b0;
      tx_err_r <= 1'b0;
      rx_err_r <= 1'b0;
      rx_ovf_r <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        irq_en_r <= avs.avs_s1_writedata[3];
      end
      tx_err_r <= tx_err_set_s | (tx_err_r & ~(wr_ctrl_s & avs.avs_s1_writedata[7]));
      rx_err_r <= rx_err_set_s | (rx_err_r & ~(wr_ctrl_s & avs.avs_s1_writedata[6]));
      rx_ovf_r <= ovf_set_s    | (rx_ovf_r & ~(wr_ctrl_s & avs.avs_s1_writedata[5]));
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      readdata_r <= 8'h00;
      irq_r      <= 1'b0;
    end else begin
      irq_r <= irq_en_r & nonempty_s;
      if (avs.avs_s1_read) begin
        case (avs.avs_s1_address)
          2'd0:    readdata_r <= nonempty_s ? mem_r[rd_ptr_r] : 8'h00;
          2'd1:    readdata_r <= status_s;
          default: readdata_r <= 8'h00;
        endcase
      end
    end
  end

  assign avs.avs_s1_readdata = readdata_r;
  assign ins_irq0_irq        = irq_r;
  assign coe_kc_oe           = kc_oe_r;
  assign coe_kd_oe           = kd_oe_r;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: a PS/2 device model on a wired-AND
// bus, Avalon read/write tasks and a scoreboard queue of expected scancodes.
module tb_ps2_kbd_ctrl;
  localparam int DEPTH = 16;
  localparam int INH   = 5000;
  localparam int TMO   = 2000;

  logic csi_clk = 1'b0;
  logic csi_reset_n = 1'b0;
  logic irq, kc_oe, kd_oe;
  logic dev_kc = 1'b1;
  logic dev_kd = 1'b1;
  logic kc_line, kd_line;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] sb_q[$];
  int kc_hi_run = 0;
  int kc_hi_last = 0;

  always #5 csi_clk = ~csi_clk;

  assign kc_line = dev_kc & ~kc_oe;
  assign kd_line = dev_kd & ~kd_oe;

  ps2_kbd_ctrl_if bus ();

  ps2_kbd_ctrl #(
    .FIFO_DEPTH(DEPTH), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .csi_clk(csi_clk), .csi_reset_n(csi_reset_n), .avs(bus.slave),
    .ins_irq0_irq(irq), .coe_kc_i(kc_line), .coe_kd_i(kd_line),
    .coe_kc_oe(kc_oe), .coe_kd_oe(kd_oe)
  );

  // Length of the most recent high pulse on the host clock pull-down.
  always @(negedge csi_clk) begin
    if (kc_oe) begin
      kc_hi_run <= kc_hi_run + 1;
    end else begin
      if (kc_hi_run != 0) kc_hi_last <= kc_hi_run;
      kc_hi_run <= 0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge csi_clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.avs_s1_address = a;
    bus.avs_s1_writedata = d;
    bus.avs_s1_write = 1'b1;
    tick(1);
    bus.avs_s1_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus.avs_s1_address = a;
    bus.avs_s1_read = 1'b1;
    tick(1);
    bus.avs_s1_read = 1'b0;
    d = bus.avs_s1_readdata;
  endtask

  task automatic chk_status(input string tag, input logic [7:0] mask, input logic [7:0] exp);
    logic [7:0] s;
    bus_read(2'd1, s);
    chk_val(tag, {24'd0, s & mask}, {24'd0, exp});
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    bus_read(2'd0, d);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    chk_val(tag, {24'd0, d}, {24'd0, e});
  endtask

  // Device-to-host frame; only the first nbits bits are clocked out.
  task automatic dev_send(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_kd = fr[i];
      tick(10);
      dev_kc = 1'b0;
      tick(20);
      dev_kc = 1'b1;
      tick(10);
    end
    dev_kd = 1'b1;
    tick(10);
    if (nbits == 11 && !bad_par && sb_q.size() < DEPTH) sb_q.push_back(b);
  endtask

  // Host-to-device reception: wait for request-to-send, clock 10 bits, then acknowledge.
  task automatic dev_accept(output logic st, output logic [7:0] data, output logic par, output logic stp);
    logic [9:0] bits;
    int waited;
    waited = 0;
    bits = 10'd0;
    st = 1'b1;
    while (!(kd_oe && !kc_oe) && waited < INH + 200) begin
      tick(1);
      waited++;
    end
    chk_val("tx_req_seen", {31'd0, kd_oe && !kc_oe}, 32'd1);
    st = kd_line;
    tick(10);
    for (int i = 0; i < 10; i++) begin
      dev_kc = 1'b0;
      tick(20);
      dev_kc = 1'b1;
      bits[i] = kd_line;
      tick(20);
    end
    dev_kd = 1'b0;
    tick(5);
    dev_kc = 1'b0;
    tick(20);
    dev_kc = 1'b1;
    tick(5);
    dev_kd = 1'b1;
    data = bits[7:0];
    par = bits[8];
    stp = bits[9];
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] v;
    logic st, par, stp;
    bus.avs_s1_address = 2'd0;
    bus.avs_s1_read = 1'b0;
    bus.avs_s1_write = 1'b0;
    bus.avs_s1_writedata = 8'h00;

    // Reset values
    tick(3);
    chk_val("rst_irq", {31'd0, irq}, 32'd0);
    chk_val("rst_kc_oe", {31'd0, kc_oe}, 32'd0);
    chk_val("rst_kd_oe", {31'd0, kd_oe}, 32'd0);
    chk_val("rst_rdata", {24'd0, bus.avs_s1_readdata}, 32'd0);
    csi_reset_n = 1'b1;
    tick(2);
    chk_status("rst_status", 8'hFF, 8'h00);

    // Single scancode
    dev_send(8'h1C, 1'b0, 11);
    chk_status("rx1_status", 8'hFF, 8'h01);
    pop_check("rx1_data");
    chk_status("rx1_empty", 8'hFF, 8'h00);
    bus_read(2'd0, d);
    chk_val("empty_pop", {24'd0, d}, 32'd0);

    // Interrupt behaviour
    bus_write(2'd1, 8'h08);
    tick(2);
    chk_val("irq_idle", {31'd0, irq}, 32'd0);
    dev_send(8'hF0, 1'b0, 11);
    chk_val("irq_rise", {31'd0, irq}, 32'd1);
    dev_send(8'h1C, 1'b0, 11);
    pop_check("irq_data0");
    chk_val("irq_hold", {31'd0, irq}, 32'd1);
    pop_check("irq_data1");
    tick(1);
    chk_val("irq_fall", {31'd0, irq}, 32'd0);

    // Overflow
    bus_write(2'd1, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 8'(i * 37 + 3);
      dev_send(v, 1'b0, 11);
    end
    chk_status("ovf_status", 8'h23, 8'h23);
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_data");
    chk_status("ovf_drained", 8'h23, 8'h20);
    bus_write(2'd1, 8'h20);
    chk_status("ovf_clear", 8'h23, 8'h00);

    // Parity error and receive timeout
    dev_send(8'h55, 1'b1, 11);
    chk_status("par_err", 8'h61, 8'h40);
    bus_write(2'd1, 8'h40);
    chk_status("rx_err_clear", 8'h40, 8'h00);
    dev_send(8'h33, 1'b0, 4);
    tick(TMO + 500);
    chk_status("rx_timeout", 8'h41, 8'h40);
    dev_send(8'h29, 1'b0, 11);
    pop_check("after_timeout");

    // Transmit with acknowledge; second write while busy must be ignored
    bus_write(2'd2, 8'hED);
    bus_write(2'd2, 8'h00);
    chk_status("tx_busy", 8'h10, 8'h10);
    dev_accept(st, d, par, stp);
    chk_val("tx_inhibit_len", kc_hi_last, INH);
    chk_val("tx_start", {31'd0, st}, 32'd0);
    chk_val("tx_data", {24'd0, d}, 32'hED);
    chk_val("tx_parity", {31'd0, par}, 32'd1);
    chk_val("tx_stop", {31'd0, stp}, 32'd1);
    tick(10);
    chk_status("tx_done", 8'h90, 8'h00);
    chk_val("tx_done_kc_oe", {31'd0, kc_oe}, 32'd0);
    chk_val("tx_done_kd_oe", {31'd0, kd_oe}, 32'd0);

    // Transmit with a silent device
    bus_write(2'd2, 8'hED);
    tick(INH + 10);
    chk_val("tx_req_kd_oe", {31'd0, kd_oe}, 32'd1);
    tick(TMO + 50);
    chk_status("tx_timeout", 8'h90, 8'h80);
    chk_val("tx_to_kc_oe", {31'd0, kc_oe}, 32'd0);
    chk_val("tx_to_kd_oe", {31'd0, kd_oe}, 32'd0);

    // Asynchronous reset during transmit releases the lines at once
    bus_write(2'd2, 8'hA5);
    tick(100);
    chk_val("mid_tx_kc_oe", {31'd0, kc_oe}, 32'd1);
    #2 csi_reset_n = 1'b0;
    #1 chk_val("async_rel_kc", {31'd0, kc_oe}, 32'd0);
    tick(2);
    csi_reset_n = 1'b1;
    tick(2);
    chk_status("post_reset", 8'hFF, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
